// File: rtl/spi_frame_master.sv
// spi_frame_master
//   SPI mode-0 master issuing one 32-bit frame per accepted start strobe:
//   a 16-bit command word followed by a 16-bit data phase. Write frames
//   (cmd_packet[1]=0) shift out data_wr; read frames shift out zeros and
//   capture spi_miso into data_rd.
//
// Ports
//   clk         system clock
//   rst_n       synchronous, active-low reset
//   start_tx    one-cycle start strobe, honoured only in IDLE
//   cmd_packet  16-bit command word, bit1 = READ flag, latched at accept
//   data_wr     16-bit write data, latched at accept
//   busy        high from accept+1 until the inter-frame gap ends
//   tx_done     one-cycle completion pulse
//   data_rd     last read data (held between read frames)
//   spi_sclk    SPI clock, idles low
//   spi_mosi    serial data out, MSB first
//   spi_cs_n    chip select, active low
//   spi_miso    serial data in
//
// Optional feature macro: SPI_READ_TURNAROUND_EN
//   When defined, read frames get one extra SCLK period after the 16th
//   (last command) bit, with mosi held low and miso ignored, so the slave
//   has a full period to turn the bus around. Write frames are unchanged.

module spi_frame_master #(
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP_CYC = 4,
  parameter int GAP_CYC      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tx,
  input  logic [15:0] cmd_packet,
  input  logic [15:0] data_wr,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] data_rd,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  // state  | meaning
  // IDLE   | waiting for start_tx, bus released
  // SETUP  | cs_n low, sclk low, CS_SETUP_CYC cycles before first edge
  // SHIFT  | 32 (or 33) SCLK periods, CLK_DIV cycles per half period
  // HOLD   | cs_n still low, sclk low, CLK_DIV cycles
  // DONE   | one cycle: cs_n high, tx_done, read data published
  // GAP    | cs_n high, GAP_CYC cycles before busy drops
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } state_t;

`ifdef SPI_READ_TURNAROUND_EN
  localparam bit TA_EN = 1'b1;
`else
  localparam bit TA_EN = 1'b0;
`endif

  // Timer reload values: the down-counter expires when it reads zero, so an
  // N-cycle interval is loaded with N-1.
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  localparam logic [5:0] BIT_FIRST = 6'd31;
  localparam logic [5:0] BIT_CMD_END = 6'd16;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] rx_q, rx_d;
  logic        rd_flag_q, rd_flag_d;
  logic        sclk_q, sclk_d;
  logic        ta_q, ta_d;
  logic [15:0] data_rd_q, data_rd_d;

  logic        frame_active;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rd_flag_d = rd_flag_q;
    sclk_d    = sclk_q;
    ta_d      = ta_q;
    data_rd_d = data_rd_q;

    case (state_q)
      ST_IDLE: begin
        if (start_tx) begin
          // Read frames send zeros in the data phase.
          shift_d   = {cmd_packet, (cmd_packet[1] ? 16'h0000 : data_wr)};
          rd_flag_d = cmd_packet[1];
          rx_d      = '0;
          bit_d     = BIT_FIRST;
          sclk_d    = 1'b0;
          ta_d      = 1'b0;
          cnt_d     = SETUP_LD;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = DIV_LD;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = DIV_LD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (!ta_q) begin
              rx_d = {rx_q[30:0], spi_miso};
            end
          end else begin
            sclk_d = 1'b0;
            if (ta_q) begin
              // End of turnaround: resume with the first data bit.
              ta_d    = 1'b0;
              shift_d = {shift_q[30:0], 1'b0};
              bit_d   = bit_q - 6'd1;
            end else if (TA_EN && rd_flag_q && (bit_q == BIT_CMD_END)) begin
              // Hold the shifter and bit count for one extra period.
              ta_d = 1'b1;
            end else if (bit_q == 6'd0) begin
              cnt_d   = DIV_LD;
              state_d = ST_HOLD;
            end else begin
              shift_d = {shift_q[30:0], 1'b0};
              bit_d   = bit_q - 6'd1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          // Publish on entry so data_rd is already valid alongside tx_done.
          if (rd_flag_q) begin
            data_rd_d = rx_q[15:0];
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        cnt_d   = GAP_LD;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      rd_flag_q <= 1'b0;
      sclk_q    <= 1'b0;
      ta_q      <= 1'b0;
      data_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rd_flag_q <= rd_flag_d;
      sclk_q    <= sclk_d;
      ta_q      <= ta_d;
      data_rd_q <= data_rd_d;
    end
  end

  assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                        (state_q == ST_HOLD);

  assign busy     = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_DONE);
  assign data_rd  = data_rd_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = ~frame_active;
  assign spi_mosi = frame_active & ~ta_q & shift_q[31];

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: reset, table-driven frames,
// hand-written ignored-start and mid-frame-reset sequences, random frames.
module tb_spi_frame_master;

  localparam int CLK_DIV      = 4;
  localparam int CS_SETUP_CYC = 4;
  localparam int GAP_CYC      = 4;
`ifdef SPI_READ_TURNAROUND_EN
  localparam bit TA = 1'b1;
`else
  localparam bit TA = 1'b0;
`endif
  localparam int RD_LAT = TA ? 273 : 265;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tx = 1'b0;
  logic [15:0] cmd_packet = '0;
  logic [15:0] data_wr = '0;
  logic        busy, tx_done;
  logic [15:0] data_rd;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b0;

  spi_frame_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP_CYC(CS_SETUP_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx), .cmd_packet(cmd_packet),
    .data_wr(data_wr), .busy(busy), .tx_done(tx_done), .data_rd(data_rd),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus monitor and mode-0 slave model, both sampled on the falling clk edge.
  logic        sclk_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0;
  int          rises = 0, done_cnt = 0, done_cyc = 0;
  int          cs_fall_cyc = 0, busy_fall_cyc = 0, sidx = 0, slv_len = 32;
  logic [32:0] mosi_cap = '0;
  logic [32:0] slv_bits = '0;
  logic [15:0] done_rd = '0;
  bit          busy_fell = 1'b0;

  always @(negedge clk) begin
    if (cs_p && !spi_cs_n) begin
      cs_fall_cyc = cyc;
      rises = 0;
      mosi_cap = '0;
      sidx = 0;
      spi_miso = slv_bits[slv_len-1];
    end
    if (!sclk_p && spi_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[31:0], spi_mosi};
    end
    if (sclk_p && !spi_sclk) begin
      sidx++;
      if (sidx < slv_len) spi_miso = slv_bits[slv_len-1-sidx];
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_rd = data_rd;
    end
    if (busy_p && !busy) begin
      busy_fell = 1'b1;
      busy_fall_cyc = cyc;
    end
    sclk_p = spi_sclk;
    cs_p = spi_cs_n;
    busy_p = busy;
  end

  // Reference model: frame shape from the protocol rules.
  function automatic int n_periods(input logic [15:0] cmd);
    return (cmd[1] && TA) ? 33 : 32;
  endfunction

  function automatic int model_lat(input logic [15:0] cmd);
    return 1 + CS_SETUP_CYC + n_periods(cmd) * 2 * CLK_DIV + CLK_DIV;
  endfunction

  function automatic logic [32:0] model_mosi(input logic [15:0] cmd, input logic [15:0] wr);
    if (!cmd[1]) return {1'b0, cmd, wr};
    if (TA) return {cmd, 17'h0};
    return {1'b0, cmd, 16'h0};
  endfunction

  task automatic load_slave(input logic [15:0] cmd, input logic [15:0] word);
    logic [16:0] junk;
    junk = 17'($urandom);
    slv_len = n_periods(cmd);
    if (slv_len == 33) slv_bits = {junk, word};
    else slv_bits = {1'b0, junk[15:0], word};
  endtask

  task automatic wait_until(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 5000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_busy_fall(input string nm);
    int g;
    g = 0;
    while (!busy_fell && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk({nm, " busy_fall_seen"}, 64'(busy_fell), 64'd1);
  endtask

  task automatic do_frame(input logic [15:0] cmd, input logic [15:0] wr,
                          input logic [15:0] slv, input logic [15:0] exp_rd,
                          input int exp_lat, input string nm);
    int t0;
    load_slave(cmd, slv);
    cmd_packet = cmd;
    data_wr = wr;
    start_tx = 1'b1;
    t0 = cyc;
    done_cnt = 0;
    busy_fell = 1'b0;
    @(negedge clk);
    start_tx = 1'b0;
    cmd_packet = 16'($urandom);
    data_wr = 16'($urandom);
    wait_busy_fall(nm);
    chk({nm, " cs_fall_lat"}, 64'(cs_fall_cyc - t0), 64'd1);
    chk({nm, " mosi"}, 64'(mosi_cap), 64'(model_mosi(cmd, wr)));
    chk({nm, " sclk_rises"}, 64'(rises), 64'(n_periods(cmd)));
    chk({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, " done_lat"}, 64'(done_cyc - t0), 64'(exp_lat));
    chk({nm, " data_rd_at_done"}, 64'(done_rd), 64'(exp_rd));
    chk({nm, " busy_fall_lat"}, 64'(busy_fall_cyc - t0), 64'(exp_lat + 1 + GAP_CYC));
    chk({nm, " data_rd_hold"}, 64'(data_rd), 64'(exp_rd));
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] wr;
    logic [15:0] slv;
    logic [15:0] exp_rd;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] model_rd;

  initial begin
    vecs[0] = '{16'h0A50, 16'hBEEF, 16'h0000, 16'h0000, 265,    "write_0A50"};
    vecs[1] = '{16'h0A52, 16'h0000, 16'h1234, 16'h1234, RD_LAT, "read_1234"};
    vecs[2] = '{16'h0002, 16'hFFFF, 16'h5A5A, 16'h5A5A, RD_LAT, "read_5A5A"};
    vecs[3] = '{16'hFFFD, 16'h0001, 16'hFFFF, 16'h5A5A, 265,    "write_FFFD"};
    vecs[4] = '{16'hFFFF, 16'h1234, 16'h8001, 16'h8001, RD_LAT, "read_8001"};

    // Reset held with start_tx high.
    rst_n = 1'b0;
    start_tx = 1'b1;
    cmd_packet = 16'h0A52;
    repeat (3) @(negedge clk);
    chk("rst cs_n", 64'(spi_cs_n), 64'd1);
    chk("rst sclk", 64'(spi_sclk), 64'd0);
    chk("rst mosi", 64'(spi_mosi), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst tx_done", 64'(tx_done), 64'd0);
    chk("rst data_rd", 64'(data_rd), 64'd0);
    start_tx = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst busy", 64'(busy), 64'd0);
    chk("post_rst cs_n", 64'(spi_cs_n), 64'd1);

    for (int i = 0; i < 5; i++) begin
      do_frame(vecs[i].cmd, vecs[i].wr, vecs[i].slv, vecs[i].exp_rd,
               vecs[i].exp_lat, vecs[i].nm);
    end
    model_rd = 16'h8001;

    // Starts during the frame and gap are ignored; the first one in IDLE wins.
    begin
      int t0;
      load_slave(16'h1111, 16'h0000);
      cmd_packet = 16'h1111;
      data_wr = 16'h2222;
      start_tx = 1'b1;
      t0 = cyc;
      done_cnt = 0;
      busy_fell = 1'b0;
      @(negedge clk);
      start_tx = 1'b0;
      cmd_packet = 16'h0002;
      wait_until(t0 + 50);
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      wait_until(t0 + 268);
      chk("ign mosi", 64'(mosi_cap), 64'({1'b0, 16'h1111, 16'h2222}));
      chk("ign sclk_rises", 64'(rises), 64'd32);
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      wait_until(t0 + 271);
      cmd_packet = 16'h3330;
      data_wr = 16'h4444;
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      wait_until(t0 + 274);
      chk("ign done_pulses", 64'(done_cnt), 64'd1);
      chk("ign done_lat", 64'(done_cyc - t0), 64'd265);
      chk("ign busy_fall_lat", 64'(busy_fall_cyc - t0), 64'd270);
      chk("ign next_cs_fall", 64'(cs_fall_cyc - t0), 64'd272);
      busy_fell = 1'b0;
      wait_busy_fall("ign_next");
      chk("ign_next mosi", 64'(mosi_cap), 64'({1'b0, 16'h3330, 16'h4444}));
      chk("ign_next done_lat", 64'(done_cyc - (t0 + 271)), 64'd265);
      chk("ign_next done_pulses", 64'(done_cnt), 64'd2);
      chk("ign data_rd", 64'(data_rd), 64'(model_rd));
    end

    // Reset in the middle of a read frame.
    begin
      int t0;
      load_slave(16'h0A52, 16'hCAFE);
      cmd_packet = 16'h0A52;
      start_tx = 1'b1;
      t0 = cyc;
      done_cnt = 0;
      @(negedge clk);
      start_tx = 1'b0;
      wait_until(t0 + 100);
      chk("mid busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid cs_n", 64'(spi_cs_n), 64'd1);
      chk("mid sclk", 64'(spi_sclk), 64'd0);
      chk("mid mosi", 64'(spi_mosi), 64'd0);
      chk("mid busy", 64'(busy), 64'd0);
      chk("mid data_rd", 64'(data_rd), 64'd0);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("mid no_done", 64'(done_cnt), 64'd0);
      do_frame(16'h8006, 16'h7777, 16'hC3A5, 16'hC3A5, RD_LAT, "mid_reread");
      model_rd = 16'hC3A5;
    end

    // Random frames against the model.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] c, w, s, e;
      c = 16'($urandom);
      w = 16'($urandom);
      s = 16'($urandom);
      e = c[1] ? s : model_rd;
      do_frame(c, w, s, e, model_lat(c), $sformatf("rand%0d", i));
      model_rd = e;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
